// File: rtl/shift_16_right_deserializer_if.sv
// Serial-in / parallel-out bundle for the right-shifting deserializer.
// The master drives the serial stream and the Ready strobe; the slave returns the framed word.
interface shift_16_right_deserializer_if #(
    parameter int W = 16
);
    logic         ShiftIn;
    logic         Enable;
    logic         Sync;
    logic         Ready;
    logic         ClrErr;
    logic [W-1:0] Q;
    logic         Valid;
    logic         Busy;
    logic         Overrun;
    logic         FrameErr;

    modport master (
        output ShiftIn, Enable, Sync, Ready, ClrErr,
        input  Q, Valid, Busy, Overrun, FrameErr
    );

    modport slave (
        input  ShiftIn, Enable, Sync, Ready, ClrErr,
        output Q, Valid, Busy, Overrun, FrameErr
    );
endinterface

// File: rtl/shift_16_right_deserializer.sv
// LSB-first serial deserializer: Sync-framed words are shifted in at the MSB,
// then handed to a parallel consumer over Valid/Ready.
//
// state | meaning
// IDLE  | waiting for a bit with Sync=1 to start a word
// RECV  | word in progress, cnt bits already accepted
module shift_16_right_deserializer #(
    parameter int    lpm_width     = 16,
    parameter string lpm_direction = "RIGHT"
) (
    input logic                          Clock,
    input logic                          Aclr,
    shift_16_right_deserializer_if.slave bus
);
    localparam int W  = lpm_width;
    localparam int CW = $clog2(W + 1);

    generate
        if (W < 2 || W > 32 || lpm_direction != "RIGHT") begin : g_bad_param
            $error("shift_16_right_deserializer: unsupported lpm_width/lpm_direction");
        end
    endgenerate

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   q_q, q_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic           frame_err_q, frame_err_d;

    logic [W-1:0]   shifted;
    logic           complete;
    logic           overrun_evt;
    logic           frame_err_evt;

    assign shifted = {bus.ShiftIn, sr_q[W-1:1]};

    always_ff @(posedge Clock or negedge Aclr) begin
        if (!Aclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock or negedge Aclr) begin
        if (!Aclr) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        complete      = 1'b0;
        frame_err_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Enable && bus.Sync) begin
                    sr_d    = shifted;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (bus.Enable && bus.Sync) begin
                    // Stale bits of the aborted word are cleared so they can never leak out.
                    sr_d          = {bus.ShiftIn, {(W-1){1'b0}}};
                    cnt_d         = CW'(1);
                    frame_err_evt = 1'b1;
                end else if (bus.Enable) begin
                    sr_d = shifted;
                    if (cnt_q == CW'(W - 1)) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        q_d         = q_q;
        valid_d     = valid_q;
        overrun_evt = 1'b0;
        if (complete) begin
            if (!valid_q || bus.Ready) begin
                q_d     = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_evt = 1'b1;
            end
        end else if (valid_q && bus.Ready) begin
            valid_d = 1'b0;
        end

        // A new error on the same edge as ClrErr keeps the flag set.
        overrun_d   = overrun_evt   | (overrun_q   & ~bus.ClrErr);
        frame_err_d = frame_err_evt | (frame_err_q & ~bus.ClrErr);
    end

    always_comb begin
        bus.Busy     = (state_q == RECV);
        bus.Q        = q_q;
        bus.Valid    = valid_q;
        bus.Overrun  = overrun_q;
        bus.FrameErr = frame_err_q;
    end
endmodule

// File: tb/tb_shift_16_right_deserializer.sv
// Directed bench for the 16-bit deserializer: stimulus queues expected words,
// a negedge monitor compares every word the DUT presents.
module tb_shift_16_right_deserializer;
    logic Clock;
    logic Aclr;
    int   checks;
    int   errors;
    logic [15:0] exp_q[$];
    logic pv, pr;

    shift_16_right_deserializer_if #(.W(16)) bus ();

    shift_16_right_deserializer #(.lpm_width(16), .lpm_direction("RIGHT")) dut (
        .Clock (Clock),
        .Aclr  (Aclr),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A new word is on Q when Valid is high and either Valid was low or
    // the previous word was handed off at the edge just taken.
    always @(negedge Clock) begin
        if (!Aclr) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (bus.Valid && (!pv || pr)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", bus.Q);
                end else begin
                    check("word", {16'h0, bus.Q}, {16'h0, exp_q.pop_front()});
                end
            end
            pv = bus.Valid;
            pr = bus.Ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        bus.ShiftIn = b;
        bus.Sync    = s;
        bus.Enable  = 1'b1;
        tick();
        bus.Enable  = 1'b0;
        bus.Sync    = 1'b0;
        bus.ShiftIn = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input logic push);
        if (push) exp_q.push_back(w);
        for (int i = 0; i < n; i++) send_bit(w[i], i == 0);
    endtask

    task automatic pulse_ready();
        bus.Ready = 1'b1;
        tick();
        bus.Ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Aclr = 1'b0;
        bus.ShiftIn = 1'b0;
        bus.Enable  = 1'b0;
        bus.Sync    = 1'b0;
        bus.Ready   = 1'b0;
        bus.ClrErr  = 1'b0;
        tick();
        check("rst_q", {16'h0, bus.Q}, 32'h0);
        check("rst_valid", {31'h0, bus.Valid}, 32'h0);
        check("rst_busy", {31'h0, bus.Busy}, 32'h0);
        check("rst_overrun", {31'h0, bus.Overrun}, 32'h0);
        check("rst_frameerr", {31'h0, bus.FrameErr}, 32'h0);
        Aclr = 1'b1;
        tick();

        // Bits without Sync in IDLE are ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("idle_nosync_busy", {31'h0, bus.Busy}, 32'h0);

        // Reset mid-word
        send_bits(16'hFFFF, 7, 1'b0);
        check("midword_busy", {31'h0, bus.Busy}, 32'h1);
        Aclr = 1'b0;
        #1;
        check("midrst_busy", {31'h0, bus.Busy}, 32'h0);
        check("midrst_valid", {31'h0, bus.Valid}, 32'h0);
        tick();
        Aclr = 1'b1;
        send_bits(16'hA55A, 16, 1'b1);
        check("a55a_q", {16'h0, bus.Q}, 32'hA55A);
        pulse_ready();
        check("a55a_drained", {31'h0, bus.Valid}, 32'h0);

        // Single word, continuous Enable, check latency edge
        exp_q.push_back(16'h1234);
        for (int i = 0; i < 15; i++) send_bit(1'(16'h1234 >> i), i == 0);
        check("1234_pre_valid", {31'h0, bus.Valid}, 32'h0);
        check("1234_pre_busy", {31'h0, bus.Busy}, 32'h1);
        send_bit(1'b0, 1'b0);
        check("1234_valid", {31'h0, bus.Valid}, 32'h1);
        check("1234_busy", {31'h0, bus.Busy}, 32'h0);
        check("1234_q", {16'h0, bus.Q}, 32'h1234);
        pulse_ready();
        check("1234_drained", {31'h0, bus.Valid}, 32'h0);

        // Gapped stream, Ready held low until done
        exp_q.push_back(16'hBEEF);
        for (int i = 0; i < 16; i++) begin
            send_bit(1'(16'hBEEF >> i), i == 0);
            tick();
        end
        tick();
        tick();
        check("beef_hold_valid", {31'h0, bus.Valid}, 32'h1);
        check("beef_q", {16'h0, bus.Q}, 32'hBEEF);
        pulse_ready();
        check("beef_drained", {31'h0, bus.Valid}, 32'h0);

        // Back-to-back: second word accepted on the same edge as the first is consumed
        send_bits(16'h0001, 16, 1'b1);
        check("b2b_first_q", {16'h0, bus.Q}, 32'h0001);
        exp_q.push_back(16'h8000);
        for (int i = 0; i < 15; i++) send_bit(1'(16'h8000 >> i), i == 0);
        check("b2b_q_before", {16'h0, bus.Q}, 32'h0001);
        check("b2b_valid_mid", {31'h0, bus.Valid}, 32'h1);
        bus.Ready = 1'b1;
        send_bit(1'b1, 1'b0);
        check("b2b_valid_after", {31'h0, bus.Valid}, 32'h1);
        check("b2b_second_q", {16'h0, bus.Q}, 32'h8000);
        check("b2b_overrun", {31'h0, bus.Overrun}, 32'h0);
        tick();
        bus.Ready = 1'b0;
        check("b2b_drained", {31'h0, bus.Valid}, 32'h0);

        // Overrun with Ready low, then clear
        send_bits(16'h1111, 16, 1'b1);
        send_bits(16'h2222, 16, 1'b0);
        check("ovr_q", {16'h0, bus.Q}, 32'h1111);
        check("ovr_flag", {31'h0, bus.Overrun}, 32'h1);
        check("ovr_valid", {31'h0, bus.Valid}, 32'h1);
        bus.ClrErr = 1'b1;
        tick();
        bus.ClrErr = 1'b0;
        check("ovr_cleared", {31'h0, bus.Overrun}, 32'h0);
        pulse_ready();

        // Resync on bit 9, aborted frame must not be emitted
        send_bits(16'hFFFF, 9, 1'b0);
        check("resync_no_err_yet", {31'h0, bus.FrameErr}, 32'h0);
        send_bits(16'h00FF, 1, 1'b1);
        check("resync_frameerr", {31'h0, bus.FrameErr}, 32'h1);
        check("resync_busy", {31'h0, bus.Busy}, 32'h1);
        for (int i = 1; i < 16; i++) send_bit(1'(16'h00FF >> i), 1'b0);
        check("resync_q", {16'h0, bus.Q}, 32'h00FF);
        check("resync_valid", {31'h0, bus.Valid}, 32'h1);
        bus.ClrErr = 1'b1;
        pulse_ready();
        bus.ClrErr = 1'b0;
        check("resync_err_cleared", {31'h0, bus.FrameErr}, 32'h0);

        tick();
        tick();
        check("queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_16_right_deserializer.md
Name: shift_16_right_deserializer

Overview:
- Receive-side counterpart of the 16-bit right-shifting LPM shift register used as a serial transmitter.
- Collects the LSB-first bit stream that the transmitter presents on ShiftOut and reassembles complete words.
- Frames each word with a Sync marker and hands it to a parallel consumer over a Valid/Ready handshake.
- Sits between the serial link and the parallel datapath in the EBR shift-register test designs.

Parameters:
- lpm_width, 16: word width W in bits; legal range 2..32.
- lpm_direction, "RIGHT": only legal value. Bits enter at the MSB and move toward bit 0, so the first bit received lands in Q[0].

Ports:
- Clock  input  1  single rising-edge clock for all state.
- Aclr  input  1  asynchronous active-low reset. Aclr=0 clears all state immediately; release is synchronous to Clock at the board level.
- ShiftIn  input  1  serial data bit; sampled only when Enable=1.
- Enable  input  1  bit strobe: exactly one serial bit is accepted per Clock edge with Enable=1.
- Sync  input  1  marks the current bit as bit 0 of a new word; meaningful only when Enable=1.
- Ready  input  1  consumer accepts Q on a Clock edge where Valid=1 and Ready=1.
- ClrErr  input  1  synchronous clear of Overrun and FrameErr.
- Q  output  W  last completed word, held stable while Valid=1.
- Valid  output  1  Q holds an unconsumed word.
- Busy  output  1  word reception in progress (state RECV).
- Overrun  output  1  sticky: a completed word was dropped.
- FrameErr  output  1  sticky: Sync arrived mid-word.

Behaviour:
- Reset (Aclr=0):
  - Q=0, Valid=0, Busy=0, Overrun=0, FrameErr=0.
  - Bit counter cnt=0; shift register sr=0; state=IDLE.
  - Asserting Aclr mid-word discards the partial word.
- Internal state:
  - sr is a W-bit shift register.
  - cnt counts bits already accepted, 0..W-1, with width ceil(log2(W+1)).
- State IDLE:
  - Enable=1 and Sync=1: sr <= {ShiftIn, sr[W-1:1]}, cnt <= 1, go to RECV.
  - Enable=1 and Sync=0: bit ignored, no flag raised.
  - Enable=0: hold.
- State RECV (Busy=1):
  - Enable=0: hold; gaps of any length are allowed.
  - Enable=1 and Sync=0: shift in the bit as above and increment cnt.
    - If this is the W-th bit (cnt==W-1 before the edge), complete the word: word = {ShiftIn, sr[W-1:1]}, cnt <= 0, go to IDLE.
  - Enable=1 and Sync=1: discard the partial word, set FrameErr, restart with this bit as bit 0 (cnt <= 1, stay in RECV).
- Word completion and output handshake (all evaluated on the same edge):
  - Valid=0: Q <= word, Valid <= 1.
  - Valid=1 and Ready=1: Q <= word, Valid stays 1 (back-to-back accepted, no bubble).
  - Valid=1 and Ready=0: word dropped, Overrun <= 1, Q and Valid unchanged.
  - No completion, Valid=1 and Ready=1: Valid <= 0; Q holds its old value.
- Latency: Valid rises on the edge that samples the W-th bit, so Q is visible in the following cycle. Minimum word period is W cycles.
- Continuous framing: a bit arriving with Sync=1 on the cycle after completion starts the next word from IDLE. Back-to-back words therefore need no idle cycle.
- ClrErr=1 clears both sticky flags on that edge. If a new error event occurs on the same edge, the flag is set (set wins over clear).
- Ready while Valid=0 has no effect.

Test Plan:
- Reset mid-word: send 7 bits of a Sync word, assert Aclr=0 -> all outputs 0 immediately. After release, a full word 0xA55A is received correctly with no stale bits.
- Single word, LSB-first: bits of 0x1234 with Sync on bit 0 and Enable continuously high -> Valid rises after the 16th edge, Q=0x1234, Busy falls on the same edge.
- Gapped stream with Ready held 0 until done: Enable toggling 1/0 around 0xBEEF -> Q=0xBEEF. Valid stays high until Ready pulses, then falls the next cycle.
- Back-to-back with Ready=1: words 0x0001 then 0x8000 with no gap -> Valid stays high across both, Q changes to 0x8000 exactly 16 cycles after the first word. Overrun stays 0.
- Overrun: Ready=0, receive 0x1111 then 0x2222 -> Q stays 0x1111 and Overrun=1. ClrErr for one cycle -> Overrun=0.
- Resync: Sync asserted on bit 9 of a word, then 16 bits of 0x00FF -> FrameErr=1, Q=0x00FF, and no word is emitted for the aborted frame.
